// File: rtl/parking_slot_manager_if.sv
// rtl/parking_slot_manager_if.sv - sensor/arrival inputs and display/gate outputs of the entry controller
interface parking_slot_manager_if;
  logic [3:0] slot_sensor;
  logic       car_arrive;
  logic [2:0] capacity;
  logic [1:0] first_empty;
  logic       full;
  logic       gate_open;
  logic [1:0] assigned_slot;
  logic       reject;
  logic       park_timeout;

  modport master (
    output slot_sensor, car_arrive,
    input  capacity, first_empty, full, gate_open, assigned_slot, reject, park_timeout
  );

  modport slave (
    input  slot_sensor, car_arrive,
    output capacity, first_empty, full, gate_open, assigned_slot, reject, park_timeout
  );
endinterface

// File: rtl/parking_slot_manager.sv
// rtl/parking_slot_manager.sv - debounced 4-slot occupancy tracker with reservation/gate FSM
module parking_slot_manager #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int GATE_CYCLES     = 1000,
  parameter int PARK_TIMEOUT    = 15000
) (
  input  logic                   clk_500Hz,
  input  logic                   reset,
  parking_slot_manager_if.slave  bus
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (GATE_CYCLES > PARK_TIMEOUT) ? GATE_CYCLES : PARK_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, OPEN, WAIT_PARK} state_t;

  logic [3:0]    sync1, sync2;
  logic [3:0]    occ, resv, busy;
  logic [DW-1:0] deb_cnt [4];
  state_t        state, state_nx;
  logic [TW-1:0] timer;
  logic [2:0]    capacity_r, capacity_nx;
  logic [1:0]    first_empty_r, first_empty_nx;
  logic          full_r;
  logic [1:0]    assigned_r;
  logic          reject_r, timeout_r;
  logic          admit, refuse, expire;
  logic          filled, timer_zero;

  always_ff @(posedge clk_500Hz) begin
    if (reset) begin
      sync1 <= 4'b0;
      sync2 <= 4'b0;
    end else begin
      sync1 <= bus.slot_sensor;
      sync2 <= sync1;
    end
  end

  // A new level is accepted only after the counter has sat at DEBOUNCE_CYCLES for one edge.
  always_ff @(posedge clk_500Hz) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        deb_cnt[i] <= '0;
        occ[i]     <= 1'b0;
      end else if (sync2[i] == occ[i]) begin
        deb_cnt[i] <= '0;
      end else if (deb_cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
        occ[i]     <= sync2[i];
        deb_cnt[i] <= '0;
      end else begin
        deb_cnt[i] <= deb_cnt[i] + 1'b1;
      end
    end
  end

  assign busy = occ | resv;

  always_comb begin
    capacity_nx = 3'd4 - {2'b0, busy[0]} - {2'b0, busy[1]}
                       - {2'b0, busy[2]} - {2'b0, busy[3]};
    first_empty_nx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!busy[i]) first_empty_nx = 2'(i);
    end
  end

  always_ff @(posedge clk_500Hz) begin
    if (reset) begin
      capacity_r    <= 3'd4;
      first_empty_r <= 2'd0;
      full_r        <= 1'b0;
    end else begin
      capacity_r    <= capacity_nx;
      first_empty_r <= first_empty_nx;
      full_r        <= (capacity_nx == 3'd0);
    end
  end

  assign filled     = occ[assigned_r];
  assign timer_zero = (timer == '0);

  always_ff @(posedge clk_500Hz) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Arrivals use last cycle's registered capacity/first_empty; filling the slot beats any timer expiry.
  always_comb begin
    state_nx = state;
    admit    = 1'b0;
    refuse   = 1'b0;
    expire   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.car_arrive) begin
          if (capacity_r == 3'd0) begin
            refuse = 1'b1;
          end else begin
            admit    = 1'b1;
            state_nx = OPEN;
          end
        end
      end
      OPEN: begin
        if (filled)          state_nx = IDLE;
        else if (timer_zero) state_nx = WAIT_PARK;
      end
      WAIT_PARK: begin
        if (filled) begin
          state_nx = IDLE;
        end else if (timer_zero) begin
          expire   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_500Hz) begin
    if (reset) begin
      timer      <= '0;
      resv       <= 4'b0;
      assigned_r <= 2'd0;
      reject_r   <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      reject_r  <= refuse;
      timeout_r <= expire;
      if (admit) begin
        assigned_r <= first_empty_r;
        resv       <= 4'b0001 << first_empty_r;
        timer      <= TW'(GATE_CYCLES - 1);
      end else if (state == OPEN && state_nx == WAIT_PARK) begin
        timer <= TW'(PARK_TIMEOUT - 1);
      end else if (state_nx == IDLE) begin
        timer <= '0;
        resv  <= 4'b0;
      end else if (!timer_zero) begin
        timer <= timer - 1'b1;
      end
    end
  end

  always_comb begin
    bus.gate_open     = (state == OPEN);
    bus.capacity      = capacity_r;
    bus.first_empty   = first_empty_r;
    bus.full          = full_r;
    bus.assigned_slot = assigned_r;
    bus.reject        = reject_r;
    bus.park_timeout  = timeout_r;
  end
endmodule

// File: tb/tb_parking_slot_manager.sv
// tb/tb_parking_slot_manager.sv - directed and randomized checks of parking_slot_manager against a timestamp model
module tb_parking_slot_manager;
  localparam int D = 20;
  localparam int G = 1000;
  localparam int T = 15000;

  logic clk = 1'b0;
  logic rst;
  parking_slot_manager_if bus_if();

  parking_slot_manager #(.DEBOUNCE_CYCLES(D), .GATE_CYCLES(G), .PARK_TIMEOUT(T)) dut (
    .clk_500Hz(clk),
    .reset(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: occupancy flips once a raw level has been sampled D+1 times in a row, seen 2 edges late.
  logic [3:0] m_occ, m_resv;
  int         m_mode;
  logic [1:0] m_asg;
  int         m_cap;
  logic [1:0] m_fe;
  bit         m_reject, m_to;
  int         cyc = 0;
  int         t_open;
  logic [3:0] hist[$];

  task automatic step();
    logic [3:0] o_occ, o_resv, o_busy;
    int         o_cap;
    logic [1:0] o_fe;
    bit         same;
    @(posedge clk);
    cyc++;
    o_occ  = m_occ;
    o_resv = m_resv;
    o_cap  = m_cap;
    o_fe   = m_fe;
    if (rst) begin
      m_occ = 4'b0; m_resv = 4'b0; m_mode = 0; m_asg = 2'd0;
      m_cap = 4; m_fe = 2'd0; m_reject = 1'b0; m_to = 1'b0;
      hist.delete();
      for (int k = 0; k < D + 3; k++) hist.push_back(4'b0);
    end else begin
      hist.push_back(bus_if.slot_sensor);
      void'(hist.pop_front());
      for (int i = 0; i < 4; i++) begin
        same = 1'b1;
        for (int k = 0; k <= D; k++) if (hist[k][i] != hist[0][i]) same = 1'b0;
        if (same && hist[0][i] != o_occ[i]) m_occ[i] = hist[0][i];
      end
      o_busy = o_occ | o_resv;
      m_cap = 4 - $countones(o_busy);
      m_fe = 2'd0;
      for (int k = 3; k >= 0; k--) if (!o_busy[k]) m_fe = 2'(k);
      m_reject = 1'b0;
      m_to     = 1'b0;
      if (m_mode == 0) begin
        if (bus_if.car_arrive) begin
          if (o_cap == 0) begin
            m_reject = 1'b1;
          end else begin
            m_mode = 1; m_asg = o_fe; m_resv = 4'b0001 << o_fe; t_open = cyc;
          end
        end
      end else if (o_occ[m_asg]) begin
        m_mode = 0; m_resv = 4'b0;
      end else if (m_mode == 1 && cyc - t_open == G) begin
        m_mode = 2;
      end else if (m_mode == 2 && cyc - t_open == G + T) begin
        m_mode = 0; m_resv = 4'b0; m_to = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.slot_sensor = 4'b0;
    bus_if.car_arrive  = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    checks++;
    if (bus_if.capacity !== 3'd4 || bus_if.first_empty !== 2'd0 || bus_if.gate_open !== 1'b0 ||
        bus_if.full !== 1'b0 || bus_if.reject !== 1'b0 || bus_if.park_timeout !== 1'b0 ||
        bus_if.assigned_slot !== 2'd0) begin
      errors++;
      $display("FAIL reset: cap=%0d fe=%0d gate=%b full=%b rej=%b to=%b asg=%0d, want cap=4 fe=0 others 0",
               bus_if.capacity, bus_if.first_empty, bus_if.gate_open, bus_if.full,
               bus_if.reject, bus_if.park_timeout, bus_if.assigned_slot);
    end
  endtask

  task automatic test_debounce();
    bit glitch_bad = 1'b0;
    bus_if.slot_sensor = 4'b0001;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == D + 3) begin
        checks++;
        if (bus_if.capacity !== 3'd4) begin
          errors++;
          $display("FAIL debounce_early: cap=%0d after %0d edges, want 4", bus_if.capacity, k);
        end
      end
      if (k == D + 4) begin
        checks++;
        if (bus_if.capacity !== 3'd3 || bus_if.first_empty !== 2'd1) begin
          errors++;
          $display("FAIL debounce_latency: cap=%0d fe=%0d after %0d edges, want 3/1",
                   bus_if.capacity, bus_if.first_empty, k);
        end
      end
    end
    bus_if.slot_sensor = 4'b0101;
    repeat (10) step();
    bus_if.slot_sensor = 4'b0001;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus_if.capacity !== 3'd3 || bus_if.first_empty !== 2'd1) glitch_bad = 1'b1;
    end
    checks++;
    if (glitch_bad) begin
      errors++;
      $display("FAIL debounce_glitch: cap=%0d fe=%0d, want 3/1 throughout", bus_if.capacity, bus_if.first_empty);
    end
  endtask

  task automatic test_admission();
    int gate_cycles;
    bus_if.car_arrive = 1'b1;
    step();
    bus_if.car_arrive = 1'b0;
    checks++;
    if (bus_if.gate_open !== 1'b1 || bus_if.assigned_slot !== 2'd1 || bus_if.capacity !== 3'd3) begin
      errors++;
      $display("FAIL admit_first_cycle: gate=%b asg=%0d cap=%0d, want 1/1/3",
               bus_if.gate_open, bus_if.assigned_slot, bus_if.capacity);
    end
    gate_cycles = 1;
    step();
    checks++;
    if (bus_if.capacity !== 3'd2 || bus_if.first_empty !== 2'd2) begin
      errors++;
      $display("FAIL admit_capacity: cap=%0d fe=%0d, want 2/2", bus_if.capacity, bus_if.first_empty);
    end
    if (bus_if.gate_open) gate_cycles++;
    for (int k = 0; k < G + 200 && bus_if.gate_open; k++) begin
      step();
      if (bus_if.gate_open) gate_cycles++;
    end
    checks++;
    if (gate_cycles != G) begin
      errors++;
      $display("FAIL gate_duration: gate high %0d cycles, want %0d", gate_cycles, G);
    end
    bus_if.slot_sensor = 4'b0011;
    repeat (30) step();
    checks++;
    if (bus_if.capacity !== 3'd2 || bus_if.first_empty !== 2'd2 || bus_if.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL admit_park: cap=%0d fe=%0d gate=%b, want 2/2/0",
               bus_if.capacity, bus_if.first_empty, bus_if.gate_open);
    end
  endtask

  task automatic test_early_park();
    int n = 0;
    bus_if.car_arrive = 1'b1;
    step();
    bus_if.car_arrive = 1'b0;
    checks++;
    if (bus_if.assigned_slot !== 2'd2 || bus_if.gate_open !== 1'b1) begin
      errors++;
      $display("FAIL early_admit: asg=%0d gate=%b, want 2/1", bus_if.assigned_slot, bus_if.gate_open);
    end
    repeat (5) step();
    bus_if.slot_sensor = 4'b0111;
    for (int k = 0; k < 100; k++) begin
      step();
      n++;
      if (!bus_if.gate_open) break;
    end
    checks++;
    if (n != D + 4 || bus_if.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL early_gate_drop: dropped after %0d edges gate=%b, want %0d and 0", n, bus_if.gate_open, D + 4);
    end
    repeat (2) step();
    checks++;
    if (bus_if.capacity !== 3'd1 || bus_if.first_empty !== 2'd3) begin
      errors++;
      $display("FAIL early_capacity: cap=%0d fe=%0d, want 1/3", bus_if.capacity, bus_if.first_empty);
    end
  endtask

  task automatic test_full();
    bus_if.slot_sensor = 4'b1111;
    repeat (30) step();
    checks++;
    if (bus_if.capacity !== 3'd0 || bus_if.first_empty !== 2'd0 || bus_if.full !== 1'b1) begin
      errors++;
      $display("FAIL full_state: cap=%0d fe=%0d full=%b, want 0/0/1",
               bus_if.capacity, bus_if.first_empty, bus_if.full);
    end
    bus_if.car_arrive = 1'b1;
    step();
    bus_if.car_arrive = 1'b0;
    checks++;
    if (bus_if.reject !== 1'b1 || bus_if.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL full_reject: reject=%b gate=%b, want 1/0", bus_if.reject, bus_if.gate_open);
    end
    step();
    checks++;
    if (bus_if.reject !== 1'b0 || bus_if.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL full_reject_pulse: reject=%b gate=%b, want 0/0", bus_if.reject, bus_if.gate_open);
    end
  endtask

  task automatic test_timeout();
    int  n = 0;
    bit  got = 1'b0;
    bus_if.slot_sensor = 4'b0111;
    repeat (30) step();
    checks++;
    if (bus_if.capacity !== 3'd1 || bus_if.first_empty !== 2'd3 || bus_if.full !== 1'b0) begin
      errors++;
      $display("FAIL timeout_setup: cap=%0d fe=%0d full=%b, want 1/3/0",
               bus_if.capacity, bus_if.first_empty, bus_if.full);
    end
    bus_if.car_arrive = 1'b1;
    step();
    bus_if.car_arrive = 1'b0;
    for (int k = 0; k < G + T + 100 && !got; k++) begin
      if (k == 5) bus_if.car_arrive = 1'b1;
      step();
      n++;
      bus_if.car_arrive = 1'b0;
      if (k == 5) begin
        checks++;
        if (bus_if.assigned_slot !== 2'd3 || bus_if.gate_open !== 1'b1 || bus_if.reject !== 1'b0) begin
          errors++;
          $display("FAIL ignored_arrival: asg=%0d gate=%b reject=%b, want 3/1/0",
                   bus_if.assigned_slot, bus_if.gate_open, bus_if.reject);
        end
      end
      if (bus_if.park_timeout) got = 1'b1;
    end
    checks++;
    if (!got || n != G + T) begin
      errors++;
      $display("FAIL timeout_latency: pulse seen=%0d after %0d edges, want 1 after %0d", got, n, G + T);
    end
    checks++;
    if (bus_if.capacity !== 3'd0) begin
      errors++;
      $display("FAIL timeout_cap_hold: cap=%0d, want 0", bus_if.capacity);
    end
    step();
    checks++;
    if (bus_if.capacity !== 3'd1 || bus_if.first_empty !== 2'd3 || bus_if.park_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: cap=%0d fe=%0d to=%b, want 1/3/0",
               bus_if.capacity, bus_if.first_empty, bus_if.park_timeout);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    rst = 1'b1;
    bus_if.slot_sensor = 4'b0;
    bus_if.car_arrive  = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 24) == 0) bus_if.slot_sensor[$urandom_range(0, 3)] ^= 1'b1;
      bus_if.car_arrive = ($urandom_range(0, 39) == 0);
      step();
      checks++;
      if (bus_if.capacity !== 3'(m_cap) || bus_if.first_empty !== m_fe || bus_if.full !== (m_cap == 0) ||
          bus_if.gate_open !== (m_mode == 1) || bus_if.assigned_slot !== m_asg ||
          bus_if.reject !== m_reject || bus_if.park_timeout !== m_to) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("FAIL random cycle %0d: cap=%0d fe=%0d full=%b gate=%b asg=%0d rej=%b to=%b, want %0d/%0d/%b/%b/%0d/%b/%b",
                   cyc, bus_if.capacity, bus_if.first_empty, bus_if.full, bus_if.gate_open,
                   bus_if.assigned_slot, bus_if.reject, bus_if.park_timeout,
                   m_cap, m_fe, (m_cap == 0), (m_mode == 1), m_asg, m_reject, m_to);
      end
    end
    bus_if.car_arrive = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus_if.slot_sensor = 4'b0000;
    repeat (30) step();
    bus_if.car_arrive = 1'b1;
    repeat (2) step();
    bus_if.car_arrive = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus_if.gate_open !== 1'b0 || bus_if.capacity !== 3'd4 || bus_if.full !== 1'b0 ||
        bus_if.assigned_slot !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: gate=%b cap=%0d full=%b asg=%0d, want 0/4/0/0",
               bus_if.gate_open, bus_if.capacity, bus_if.full, bus_if.assigned_slot);
    end
    repeat (3) step();
    checks++;
    if (bus_if.capacity !== 3'd4 || bus_if.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: cap=%0d gate=%b, want 4/0", bus_if.capacity, bus_if.gate_open);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_admission();
    test_early_park();
    test_full();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/parking_slot_manager.md
# parking_slot_manager

Occupancy tracker and entry-gate controller for the 4-slot lot. It debounces the four slot sensors and arbitrates car arrivals through a reservation/gate state machine. It produces the registered `capacity` and `first_empty` values that feed `ParkingDisplay` directly. It runs on the same 500 Hz system clock as the display.

## Interface
- `DEBOUNCE_CYCLES`, 20: cycles a slot sensor must hold a new level before it is accepted (40 ms at 500 Hz).
- `GATE_CYCLES`, 1000: cycles the gate is held open (2 s).
- `PARK_TIMEOUT`, 15000: maximum cycles to wait for the admitted car to occupy its slot (30 s).

Ports:
- `clk_500Hz` in, 1: system clock; all logic is on the rising edge.
- `reset` in, 1: synchronous, active-high.
- `slot_sensor` in, 4: raw occupancy sensors, bit i = slot i, 1 = car present. Asynchronous to the clock.
- `car_arrive` in, 1: single-cycle pulse from the entry detector.
- `capacity` out, 3: number of free, unreserved slots, 0..4.
- `first_empty` out, 2: lowest-index free, unreserved slot; 0 when `capacity`=0.
- `full` out, 1: high when `capacity`==0.
- `gate_open` out, 1: entry barrier drive.
- `assigned_slot` out, 2: slot reserved for the car currently being admitted.
- `reject` out, 1: one-cycle pulse when an arrival is refused because the lot is full.
- `park_timeout` out, 1: one-cycle pulse when a reservation expires.

## Operation
- **Sync:** each `slot_sensor` bit passes through a 2-flop synchronizer before debounce.
- **Debounce:** there is one counter per slot, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - The counter resets whenever the synchronized bit equals the debounced bit `occ[i]`.
  - Otherwise it increments. When it reaches `DEBOUNCE_CYCLES`, `occ[i]` takes the new level and the counter clears.
- **Reservation:** `resv[3:0]` is a one-hot register or zero. At most one bit is set at a time.
- **Derived values:** `busy = occ | resv`.
  - `capacity` = 4 − popcount(`busy`).
  - `first_empty` = lowest i with `busy[i]`=0, or 0 if there is none.
  - `full` = (`capacity`==0).
  - All three are registered.
- **FSM** (states IDLE, OPEN, WAIT_PARK):
  - **IDLE:**
    - If `car_arrive` and `capacity`==0: pulse `reject`, stay in IDLE.
    - If `car_arrive` and `capacity`>0: latch `assigned_slot` = `first_empty`, set `resv[first_empty]`, load the gate counter, go to OPEN.
  - **OPEN:**
    - `gate_open`=1. The counter counts `GATE_CYCLES`, then the FSM goes to WAIT_PARK.
    - If `occ[assigned_slot]` rises during OPEN: clear `resv`, drop the gate, go to IDLE.
  - **WAIT_PARK:**
    - `gate_open`=0.
    - If `occ[assigned_slot]` rises: clear `resv`, go to IDLE.
    - After `PARK_TIMEOUT` cycles: clear `resv`, pulse `park_timeout`, go to IDLE.
- `car_arrive` is ignored outside IDLE; no queuing.
- **Wrong slot:** if the car parks in a slot other than `assigned_slot`, `occ` updates normally and the reservation persists until the assigned slot fills or the timeout expires.
- **Simultaneous events:**
  - A sensor accept and `car_arrive` in the same cycle: the arrival uses the `capacity`/`first_empty` register values from the previous cycle.
  - A reserved slot whose `occ` clears (car leaves) has no effect on the reservation.

## Timing
- **Reset values:**
  - `occ`=0, `resv`=0, all counters 0, FSM=IDLE.
  - `capacity`=4, `first_empty`=0, `full`=0.
  - `gate_open`=0, `assigned_slot`=0, `reject`=0, `park_timeout`=0.
- **Reset mid-operation:** reset dominates everything. The gate closes and the reservation drops on the next edge.
- **Sensor latency:** a sensor change held stable from edge N gives 2 cycles of sync, then `occ` updates at N+2+`DEBOUNCE_CYCLES`. `capacity`/`first_empty` update 1 cycle later.
- **Glitches:** a glitch shorter than `DEBOUNCE_CYCLES` never reaches `occ`.
- **Arrival latency:** `car_arrive` sampled at edge N produces the following at N+1:
  - `gate_open`=1, `assigned_slot` valid, `resv` set.
  - `capacity` decrements at N+2.
- **Gate duration:** `gate_open` stays high for exactly `GATE_CYCLES` cycles unless cut short by occupancy.
- **Reject:** `reject` is high for exactly the cycle after the refused `car_arrive`.
- **Timeout:** `park_timeout` fires `GATE_CYCLES`+`PARK_TIMEOUT` cycles after OPEN entry. `resv` clears and `capacity` recovers 1 cycle later.

## Test plan
1. **Reset:** hold `reset` for 3 cycles, all sensors 0 → `capacity`=4, `first_empty`=0, `gate_open`=0, `full`=0.
2. **Debounce:** set `slot_sensor`=0001 stable for 25 cycles → `capacity`=3, `first_empty`=1. A 10-cycle pulse on bit 2 → no change.
3. **Admission:**
   - With `occ`=0001, pulse `car_arrive` → `assigned_slot`=1, `capacity`=2, `first_empty`=2, `gate_open` high 1000 cycles.
   - Then set sensor bit 1 → `resv` clears, `capacity` stays 2.
4. **Early park:** during OPEN, set the assigned slot's sensor → `gate_open` drops within 2+`DEBOUNCE_CYCLES`+1 cycles, FSM returns to IDLE.
5. **Full lot:** `slot_sensor`=1111 debounced → `capacity`=0, `first_empty`=0, `full`=1. `car_arrive` → one-cycle `reject`, `gate_open` stays 0.
6. **Timeout and ignored arrival:**
   - Admit to slot 3 and never occupy it → `park_timeout` pulse after 16000 cycles, `capacity` restores.
   - A second `car_arrive` during OPEN is ignored.
